// File: rtl/uart_txbuf.sv
// rtl/uart_txbuf.sv - byte FIFO and one-frame-at-a-time pacer feeding the UART transmitter

// Byte queue with registered occupancy flags and a sticky overflow flag.
// A write into a full queue is dropped. "Full" means full before the edge,
// so a write is still dropped when a read happens on the same edge.
module uart_txbuf_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic [ADDR_W:0]   count_n;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // next occupancy: a simultaneous push and pop leave it unchanged
  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + 1'b1;
    end else if (pop && !push) begin
      count_n = count - 1'b1;
    end
  end

  // storage write; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers, occupancy and flags; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == DEPTH_C);
    end
  end

endmodule

// Pacer: pops one byte, strobes the transmitter once, waits for the frame
// to start and finish (or for the start timeout), then idles GAP_CYCLES
// clocks before looking at the queue again.
module uart_txbuf #(
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 16,
  parameter int START_TO   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_wrsig,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_wrsig,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] STROBE     = 3'd2;
  localparam logic [2:0] WAIT_START = 3'd3;
  localparam logic [2:0] WAIT_DONE  = 3'd4;
  localparam logic [2:0] GAP        = 3'd5;

  // terminal values: the timer reads 0 on the first cycle in a state
  localparam logic [15:0] START_LAST = 16'(START_TO - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic [15:0] tmr;
  logic [7:0]  rd_data;
  logic        pop;

  assign pop = (state == LOAD);

  uart_txbuf_fifo #(
    .ADDR_W   (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (in_data),
    .wr_en    (in_wrsig),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  // next-state logic; a start timeout drops the byte rather than retrying it
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        state_n = STROBE;
      end
      STROBE: begin
        state_n = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (tmr == START_LAST) begin
          state_n = GAP;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_n = GAP;
        end
      end
      GAP: begin
        if (tmr == GAP_LAST) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state register; a reset mid-frame abandons the frame, the transmitter finishes alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // dwell timer: cleared on every state change, counts only where it is compared
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr <= '0;
    end else if (state_n != state) begin
      tmr <= '0;
    end else if (state == WAIT_START || state == GAP) begin
      tmr <= tmr + 1'b1;
    end
  end

  // transmitter outputs: data latched on the pop, strobe high for the STROBE cycle only
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_data  <= 8'h00;
      tx_wrsig <= 1'b0;
    end else begin
      tx_wrsig <= (state == LOAD);
      if (state == LOAD) begin
        tx_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_txbuf.sv
// tb/tb_uart_txbuf.sv - scoreboard bench for uart_txbuf
module tb_uart_txbuf;

  localparam int ADDR_W = 4;

  logic              clk        = 1'b0;
  logic              reset      = 1'b0;
  logic [7:0]        in_data    = 8'h00;
  logic              in_wrsig   = 1'b0;
  logic              model_busy = 1'b0;
  logic              hold_busy  = 1'b0;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_wrsig;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;

  assign tx_busy = model_busy | hold_busy;

  uart_txbuf #(
    .ADDR_W     (ADDR_W),
    .GAP_CYCLES (16),
    .START_TO   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_wrsig (in_wrsig),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_wrsig (tx_wrsig),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  int         strobe_cnt = 0;
  int         last_strobe_cyc = 0;
  int         busy_fall_cyc = 0;
  logic       prev_wrsig = 1'b0;
  bit         xmit_en = 1'b1;
  int         busy_len = 160;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // strobe monitor and scoreboard consumer
  always @(negedge clk) begin
    if (tx_wrsig === 1'b1) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      check("wrsig_single", {31'd0, prev_wrsig}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else check("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
    prev_wrsig = (tx_wrsig === 1'b1);
  end

  // transmitter model: busy rises 2 cycles after the strobe, lasts busy_len cycles
  initial begin
    forever begin
      @(negedge clk);
      if (tx_wrsig === 1'b1 && xmit_en) begin
        @(negedge clk);
        @(negedge clk);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    in_data  = d;
    in_wrsig = 1'b1;
    if (accept) exp_q.push_back(d);
    tick();
    in_wrsig = 1'b0;
  endtask

  task automatic wait_strobe(input int budget);
    int start;
    int n;
    start = strobe_cnt;
    n = 0;
    while (strobe_cnt == start && n < budget) begin
      tick();
      n++;
    end
    if (strobe_cnt == start) check("strobe_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n0;
    int s1;
    int sc;

    // reset with in_wrsig toggling
    for (int i = 0; i < 4; i++) begin
      in_data  = 8'($urandom);
      in_wrsig = ~in_wrsig;
      tick();
    end
    reset    = 1'b1;
    in_wrsig = 1'b0;
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_wrsig", 32'(tx_wrsig), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);

    // single push latency, then a second byte paced behind a 160-cycle frame
    busy_len = 160;
    xmit_en  = 1'b1;
    push(8'hA5, 1'b1);
    n0 = cyc;
    check("lat_count_n", 32'(count), 32'd1);
    check("lat_empty_n", 32'(empty), 32'd0);
    tick();
    check("lat_data_n1", 32'(tx_data), 32'h00);
    check("lat_wrsig_n1", 32'(tx_wrsig), 32'd0);
    tick();
    check("lat_data_n2", 32'(tx_data), 32'hA5);
    check("lat_wrsig_n2", 32'(tx_wrsig), 32'd1);
    tick();
    check("lat_wrsig_n3", 32'(tx_wrsig), 32'd0);
    check("lat_strobe_cyc", 32'(last_strobe_cyc), 32'(n0 + 2));
    repeat (10) tick();
    push(8'h5A, 1'b1);
    wait_strobe(400);
    check("gap_after_busy", 32'(last_strobe_cyc - busy_fall_cyc >= 16), 32'd1);
    repeat (200) tick();

    // burst of 16 while the pacer is held in a frame, then one overflow write
    busy_len  = 20;
    hold_busy = 1'b1;
    push(8'hEE, 1'b1);
    wait_strobe(10);
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    check("burst_count", 32'(count), 32'd16);
    check("burst_full", 32'(full), 32'd1);
    check("burst_no_ovf", 32'(overflow), 32'd0);
    push(8'hFF, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    hold_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_strobe(200);
      check("drain_count", 32'(count), 32'(15 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    repeat (60) tick();

    // transmitter never goes busy: start timeout then gap, strobes 27 clocks apart
    xmit_en = 1'b0;
    push(8'h31, 1'b1);
    push(8'h32, 1'b1);
    wait_strobe(10);
    s1 = last_strobe_cyc;
    wait_strobe(60);
    check("timeout_interval", 32'(last_strobe_cyc - s1), 32'd27);
    repeat (40) tick();

    // reset while waiting for frame end with 5 bytes queued
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h41 + 8'(i), 1'b1);
    repeat (3) tick();
    check("mid_count", 32'(count), 32'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_wrsig", 32'(tx_wrsig), 32'd0);
    hold_busy = 1'b0;
    sc = strobe_cnt;
    repeat (60) tick();
    check("mid_rst_no_strobe", 32'(strobe_cnt), 32'(sc));
    push(8'h77, 1'b1);
    wait_strobe(10);
    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_txbuf.md
Name: uart_txbuf

Overview:
- Byte FIFO and transmit pacer between the UART control logic and the UART transmitter.
- Control logic can burst several bytes back-to-back, each with a one-cycle strobe. This block queues them.
- It feeds the transmitter one byte at a time: a single write strobe per byte, then it waits for that frame to complete before issuing the next.
- Runs entirely on the 16x-baud clock from the clock divider.

Parameters:
- ADDR_W, 4, log2 of FIFO depth (depth = 16 bytes)
- GAP_CYCLES, 16, idle clocks inserted after each frame before the next strobe (16 = one bit time)
- START_TO, 8, max clocks to wait for tx_busy to rise after a strobe

Ports:
- clk  in  1  16x-baud clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- in_data  in  8  byte from control logic
- in_wrsig  in  1  one-cycle write strobe for in_data
- tx_busy  in  1  transmitter status; high while a frame is on the line
- tx_data  out  8  byte presented to transmitter
- tx_wrsig  out  1  one-cycle start strobe to transmitter
- count  out  ADDR_W+1  bytes currently queued (0..16)
- empty  out  1  count==0
- full  out  1  count==16
- overflow  out  1  sticky; a write arrived while full

Behaviour:
- Reset: reset==0 at a rising edge clears rd/wr pointers and sets count=0, empty=1, full=0, overflow=0, tx_wrsig=0, tx_data=8'h00, state=IDLE. Memory contents are not cleared.
- Reset mid-frame discards all queued bytes. The transmitter is not reset by this block, and an in-flight frame completes on its own.
- Push:
  - in_wrsig=1 and full=0 at an edge: write in_data at wr pointer, increment wr (wraps 15->0), count+1.
  - in_wrsig=1 and full=1: byte dropped, overflow<=1, pointers and count unchanged.
  - Full is evaluated on pre-edge state, so a push coinciding with a pop while full is still dropped.
- Pop occurs only in LOAD: tx_data<=mem[rd], increment rd (wraps), count-1.
- Same-edge push and pop (count not full): count unchanged, both pointers advance.
- Push into empty FIFO while in IDLE: the byte is popped on the following edge, so there is no bypass path.
- State machine (one transition per edge):
  - IDLE: if count!=0 -> LOAD.
  - LOAD: pop, -> STROBE.
  - STROBE: tx_wrsig=1 for exactly this state's cycle, -> WAIT_START.
  - WAIT_START: tx_busy=1 -> WAIT_DONE. Otherwise, after START_TO cycles in this state -> GAP; the byte is considered sent and is not retried.
  - WAIT_DONE: tx_busy=0 -> GAP.
  - GAP: count GAP_CYCLES clocks, then -> IDLE.
- Latency: byte written at edge N into an empty FIFO with the state machine in IDLE gives LOAD state after edge N+1, tx_data valid after edge N+2, and tx_wrsig high during cycle N+2..N+3.
- Outputs:
  - tx_wrsig is registered and never high for two consecutive cycles.
  - tx_data is stable from LOAD until the next LOAD.
  - empty, full and count are registered and consistent with each other every cycle.
- Strobes: in_wrsig held high for multiple cycles pushes once per cycle. Upstream must pulse.
- Throughput: at most one byte per (frame time + GAP_CYCLES + 3) clocks.

Test Plan:
- Reset with in_wrsig toggling -> after first edge with reset=1: count=0, empty=1, full=0, overflow=0, tx_wrsig=0, tx_data=00.
- Single push 8'hA5 at edge N, transmitter model raises tx_busy 2 cycles after strobe for 160 cycles -> tx_data=A5 after N+2, single tx_wrsig pulse in cycle N+2, next strobe no earlier than 16 cycles after tx_busy falls.
- Burst of 16 pushes 00..0F on consecutive cycles -> full=1, count=16 after the 16th. Transmitted order is 00..0F, one strobe each; count decrements by 1 per LOAD; empty=1 after the last LOAD.
- 17 back-to-back pushes before any pop (state machine held by tx_busy=1) -> 17th byte dropped, overflow=1 and sticky until reset, byte 16 not overwritten.
- tx_busy held 0 after strobe -> WAIT_START exits after 8 cycles, then GAP 16 cycles, then next byte strobed; no lockup.
- Reset asserted during WAIT_DONE with 5 bytes queued -> count=0, empty=1, state IDLE, no further tx_wrsig until a new push.
